// File: rtl/icache_ro.sv
// Read-only, direct-mapped instruction cache: 8 lines of 4 words each.
// Hits return the selected word in the same cycle. A miss stalls the
// processor while one line is fetched from the downstream memory stage.
// Saturating counters record hits and line fetches.
module icache_ro #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             proc_read,
   input  logic [29:0]      proc_addr,
   output logic [31:0]      proc_rdata,
   output logic             proc_stall,
   output logic             mem_read,
   output logic [27:0]      mem_addr,
   input  logic [127:0]     mem_rdata,
   input  logic             mem_ready,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic {
      S_IDLE,
      S_FETCH
   } state_t;

   state_t           state_q, state_d;

   logic [127:0]     dataArr_q [8];
   logic [24:0]      tagArr_q  [8];
   logic [7:0]       valid_q, valid_d;

   logic             memRead_q, memRead_d;
   logic [27:0]      memAddr_q, memAddr_d;

   logic [CNT_W-1:0] hitCnt_q, hitCnt_d;
   logic [CNT_W-1:0] missCnt_q, missCnt_d;

   logic [1:0]       reqOffset;
   logic [2:0]       reqIndex;
   logic [24:0]     reqTag;
   logic [2:0]       fillIndex;
   logic [24:0]      fillTag;
   logic [127:0]     indexedLine;
   logic             tagMatch;
   logic             hit;
   logic             refillEn;
   logic             missStart;

   // The outstanding line address doubles as the latched refill tag/index,
   // so the refill never depends on whatever the processor drives later.
   assign reqOffset   = proc_addr[1:0];
   assign reqIndex    = proc_addr[4:2];
   assign reqTag      = proc_addr[29:5];
   assign fillIndex   = memAddr_q[2:0];
   assign fillTag     = memAddr_q[27:3];

   assign indexedLine = dataArr_q[reqIndex];
   assign tagMatch    = valid_q[reqIndex] && (tagArr_q[reqIndex] == reqTag);

   // While reset is asserted the cache behaves as if already cleared: nothing
   // hits, and any read request stalls.
   assign hit         = !rst && (state_q == S_IDLE) && proc_read && tagMatch;
   assign proc_stall  = rst ? proc_read
                            : ((proc_read && !hit) || (state_q == S_FETCH));

   assign proc_rdata  = indexedLine[{reqOffset, 5'b00000} +: 32];

   assign mem_read    = memRead_q;
   assign mem_addr    = memAddr_q;
   assign hit_cnt     = hitCnt_q;
   assign miss_cnt    = missCnt_q;

   // Next-state logic: start a line fetch on a miss, finish it on mem_ready.
   always_comb begin
      state_d   = state_q;
      memRead_d = memRead_q;
      memAddr_d = memAddr_q;
      valid_d   = valid_q;
      refillEn  = 1'b0;
      missStart = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (proc_read && !hit) begin
               state_d   = S_FETCH;
               memRead_d = 1'b1;
               memAddr_d = proc_addr[29:2];
               missStart = 1'b1;
            end
         end
         S_FETCH: begin
            if (mem_ready) begin
               state_d             = S_IDLE;
               memRead_d           = 1'b0;
               refillEn            = !rst;
               valid_d[fillIndex]  = 1'b1;
            end
         end
         default: begin
            state_d   = S_IDLE;
            memRead_d = 1'b0;
         end
      endcase
   end

   // Saturating statistics: hits per hit cycle, misses per fetch started.
   always_comb begin
      hitCnt_d  = hitCnt_q;
      missCnt_d = missCnt_q;
      if (hit && (hitCnt_q != CNT_MAX)) begin
         hitCnt_d = hitCnt_q + CNT_ONE;
      end
      if (missStart && (missCnt_q != CNT_MAX)) begin
         missCnt_d = missCnt_q + CNT_ONE;
      end
   end

   // Control state, valid bits and counters; reset aborts any refill.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         valid_q   <= 8'h00;
         memRead_q <= 1'b0;
         memAddr_q <= 28'h0;
         hitCnt_q  <= '0;
         missCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         memRead_q <= memRead_d;
         memAddr_q <= memAddr_d;
         hitCnt_q  <= hitCnt_d;
         missCnt_q <= missCnt_d;
      end
   end

   // Data and tag storage are only meaningful behind a valid bit, so they
   // are written on refill and never cleared.
   always_ff @(posedge clk) begin
      if (refillEn) begin
         dataArr_q[fillIndex] <= mem_rdata;
         tagArr_q[fillIndex]  <= fillTag;
      end
   end

endmodule

// File: tb/tb_icache_ro.sv
// Self-checking bench for icache_ro: a table of directed vectors, a few
// hand-written multi-cycle sequences and a randomized run, all checked
// against a line-residency model of a direct-mapped cache in front of a
// synthetic instruction memory.
module tb_icache_ro;

   localparam int CNT_W = 4;
   localparam int CMAX  = 15;

   logic             clk;
   logic             rst;
   logic             proc_read;
   logic [29:0]      proc_addr;
   logic [31:0]      proc_rdata;
   logic             proc_stall;
   logic             mem_read;
   logic [27:0]      mem_addr;
   logic [127:0]     mem_rdata;
   logic             mem_ready;
   logic [CNT_W-1:0] hit_cnt;
   logic [CNT_W-1:0] miss_cnt;

   int checkCount = 0;
   int passCount  = 0;

   bit          residentValid [8];
   logic [27:0] residentLine  [8];
   logic [27:0] pendQ [$];
   int          modelHits   = 0;
   int          modelMisses = 0;

   bit          curRs, curRd, curRdy, curBusy, curExpHit, curExpStall;
   logic [27:0] curLine;

   typedef struct {
      bit          rs;
      bit          rd;
      logic [29:0] addr;
      bit          rdy;
      bit          expStall;
      bit          expMemRead;
      logic [27:0] expMemAddr;
      bit          chkData;
      logic [31:0] expRdata;
      int          expHits;
      int          expMisses;
   } vec_t;

   vec_t vecs [12];

   icache_ro #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .proc_read  (proc_read),
      .proc_addr  (proc_addr),
      .proc_rdata (proc_rdata),
      .proc_stall (proc_stall),
      .mem_read   (mem_read),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] memWord(input logic [29:0] wa);
      return {wa[15:0], ~wa[15:0]} ^ 32'h1234_5678;
   endfunction

   function automatic logic [127:0] memLine(input logic [27:0] ln);
      return {memWord({ln, 2'd3}), memWord({ln, 2'd2}),
              memWord({ln, 2'd1}), memWord({ln, 2'd0})};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   // Drive one cycle's inputs and compare outputs against the model.
   task automatic applyStimulus(input bit rs, input bit rd,
                                input logic [29:0] addr, input bit rdy);
      int idx;
      curRs   = rs;
      curRd   = rd;
      curRdy  = rdy;
      curLine = addr[29:2];
      idx     = int'(addr[4:2]);
      curBusy = (pendQ.size() != 0);
      rst       = rs;
      proc_read = rd;
      proc_addr = addr;
      mem_ready = rdy;
      if (rdy && curBusy) mem_rdata = memLine(pendQ[0]);
      else mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      #1;
      if (rs) begin
         curExpHit   = 1'b0;
         curExpStall = rd;
      end else begin
         curExpHit   = !curBusy && rd && residentValid[idx] &&
                       (residentLine[idx] == curLine);
         curExpStall = (rd && !curExpHit) || curBusy;
      end
      checkOutput("stall", 32'(proc_stall), 32'(curExpStall));
      checkOutput("memRead", 32'(mem_read), 32'(curBusy));
      if (curBusy) checkOutput("memAddr", 32'(mem_addr), 32'(pendQ[0]));
      checkOutput("hitCnt", 32'(hit_cnt), 32'(modelHits));
      checkOutput("missCnt", 32'(miss_cnt), 32'(modelMisses));
      if (curExpHit) checkOutput("rdata", proc_rdata, memWord(addr));
   endtask

   // Clock edge, then advance the model by the rules of the cache.
   task automatic advance();
      logic [27:0] p;
      @(posedge clk);
      #1;
      if (curRs) begin
         for (int i = 0; i < 8; i++) residentValid[i] = 1'b0;
         pendQ.delete();
         modelHits   = 0;
         modelMisses = 0;
      end else if (curBusy) begin
         if (curRdy) begin
            p = pendQ.pop_front();
            residentValid[p[2:0]] = 1'b1;
            residentLine[p[2:0]]  = p;
         end
      end else if (curExpHit) begin
         if (modelHits < CMAX) modelHits++;
      end else if (curRd) begin
         pendQ.push_back(curLine);
         if (modelMisses < CMAX) modelMisses++;
      end
   endtask

   task automatic cycle(input bit rs, input bit rd, input logic [29:0] addr,
                        input bit rdy);
      applyStimulus(rs, rd, addr, rdy);
      advance();
   endtask

   task automatic fullMiss(input logic [29:0] addr, input int lat);
      cycle(1'b0, 1'b1, addr, 1'b0);
      repeat (lat) cycle(1'b0, 1'b1, addr, 1'b0);
      cycle(1'b0, 1'b1, addr, 1'b1);
   endtask

   task automatic setVec(input int i, input bit rd, input logic [29:0] addr,
                         input bit rdy, input bit st, input bit mr,
                         input logic [27:0] ma, input bit cd,
                         input logic [31:0] rdv, input int h, input int m);
      vecs[i] = '{rs: 1'b0, rd: rd, addr: addr, rdy: rdy, expStall: st,
                  expMemRead: mr, expMemAddr: ma, chkData: cd,
                  expRdata: rdv, expHits: h, expMisses: m};
   endtask

   initial begin
      logic [29:0] ra;
      bit          rr, rdy, rs;

      for (int i = 0; i < 8; i++) begin
         residentValid[i] = 1'b0;
         residentLine[i]  = '0;
      end
      rst       = 1'b1;
      proc_read = 1'b0;
      proc_addr = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;

      // Cold miss on word 5, mem_ready four cycles after mem_read rises,
      // then same-line hits on words 4, 6, 7.
      setVec(0,  0, 30'h0, 0, 0, 0, 28'h0, 0, 32'h0,            0, 0);
      setVec(1,  1, 30'h5, 0, 1, 0, 28'h0, 0, 32'h0,            0, 0);
      setVec(2,  1, 30'h5, 0, 1, 1, 28'h1, 0, 32'h0,            0, 1);
      setVec(3,  1, 30'h5, 0, 1, 1, 28'h1, 0, 32'h0,            0, 1);
      setVec(4,  1, 30'h5, 0, 1, 1, 28'h1, 0, 32'h0,            0, 1);
      setVec(5,  1, 30'h5, 0, 1, 1, 28'h1, 0, 32'h0,            0, 1);
      setVec(6,  1, 30'h5, 1, 1, 1, 28'h1, 0, 32'h0,            0, 1);
      setVec(7,  1, 30'h5, 0, 0, 0, 28'h0, 1, memWord(30'h5),   0, 1);
      setVec(8,  1, 30'h4, 0, 0, 0, 28'h0, 1, memWord(30'h4),   1, 1);
      setVec(9,  1, 30'h6, 0, 0, 0, 28'h0, 1, memWord(30'h6),   2, 1);
      setVec(10, 1, 30'h7, 0, 0, 0, 28'h0, 1, memWord(30'h7),   3, 1);
      setVec(11, 0, 30'h0, 0, 0, 0, 28'h0, 0, 32'h0,            4, 1);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].rs, vecs[i].rd, vecs[i].addr, vecs[i].rdy);
         checkOutput($sformatf("vec%0d.stall", i), 32'(proc_stall),
                     32'(vecs[i].expStall));
         checkOutput($sformatf("vec%0d.memRead", i), 32'(mem_read),
                     32'(vecs[i].expMemRead));
         if (vecs[i].expMemRead || i == 0)
            checkOutput($sformatf("vec%0d.memAddr", i), 32'(mem_addr),
                        32'(vecs[i].expMemAddr));
         if (vecs[i].chkData)
            checkOutput($sformatf("vec%0d.rdata", i), proc_rdata,
                        vecs[i].expRdata);
         checkOutput($sformatf("vec%0d.hitCnt", i), 32'(hit_cnt),
                     32'(vecs[i].expHits));
         checkOutput($sformatf("vec%0d.missCnt", i), 32'(miss_cnt),
                     32'(vecs[i].expMisses));
         advance();
      end

      // Conflict: 0x25 evicts line 1 from index 1, so 0x5 misses again.
      fullMiss(30'h25, 2);
      cycle(1'b0, 1'b1, 30'h25, 1'b0);
      applyStimulus(1'b0, 1'b1, 30'h5, 1'b0);
      checkOutput("conflictStall", 32'(proc_stall), 32'd1);
      advance();
      repeat (2) cycle(1'b0, 1'b1, 30'h5, 1'b0);
      cycle(1'b0, 1'b1, 30'h5, 1'b1);
      applyStimulus(1'b0, 1'b1, 30'h5, 1'b0);
      checkOutput("conflictMissCnt", 32'(miss_cnt), 32'd3);
      checkOutput("conflictRefetch", proc_rdata, memWord(30'h5));
      advance();

      // Reset during a fetch aborts it; a late mem_ready is ignored.
      cycle(1'b0, 1'b1, 30'h48, 1'b0);
      cycle(1'b0, 1'b1, 30'h48, 1'b0);
      applyStimulus(1'b1, 1'b1, 30'h48, 1'b0);
      checkOutput("rstStall", 32'(proc_stall), 32'd1);
      advance();
      applyStimulus(1'b0, 1'b0, 30'h48, 1'b1);
      checkOutput("abortMemRead", 32'(mem_read), 32'd0);
      advance();
      applyStimulus(1'b0, 1'b1, 30'h48, 1'b0);
      checkOutput("abortMiss", 32'(proc_stall), 32'd1);
      checkOutput("abortHitCnt", 32'(hit_cnt), 32'd0);
      advance();
      cycle(1'b0, 1'b1, 30'h48, 1'b0);
      cycle(1'b0, 1'b1, 30'h48, 1'b1);

      // Hit counter saturates at 15 after 20 hits.
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 30'h48 | 30'(i % 4), 1'b0);
      applyStimulus(1'b0, 1'b0, 30'h0, 1'b0);
      checkOutput("satHitCnt", 32'(hit_cnt), 32'd15);
      checkOutput("satMissCnt", 32'(miss_cnt), 32'd1);
      advance();

      // Stray mem_ready in idle carries garbage and must change nothing.
      cycle(1'b0, 1'b0, 30'h49, 1'b1);
      applyStimulus(1'b0, 1'b1, 30'h49, 1'b0);
      checkOutput("strayHit", 32'(proc_stall), 32'd0);
      checkOutput("strayData", proc_rdata, memWord(30'h49));
      checkOutput("strayMissCnt", 32'(miss_cnt), 32'd1);
      advance();

      // Randomized traffic over three tags so lines conflict often.
      ra = 30'h0;
      rr = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if (!(curExpStall && curRd)) begin
            rr = ($urandom % 5) != 0;
            ra = 30'((($urandom % 3) * 32) + ($urandom % 32));
         end
         if (pendQ.size() != 0) rdy = ($urandom % 3) == 0;
         else rdy = ($urandom % 20) == 0;
         rs = ($urandom % 100) == 0;
         cycle(rs, rr, ra, rdy);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
